regbank_write_arbiter: RTL and testbench
========================================

Name: regbank_write_arbiter

Overview:
Round-robin arbiter that shares the 16x16 register bank's single write port among NUM_REQ requesters, for example the ALU writeback, the load unit and the debug port.
It also sequences bank clears. A requested clear drains in-flight writes, pulses the bank's clear input for exactly one cycle, then acknowledges.
It sits between the datapath producers and the bank's write port (write_enable, address_w, data_in_w, clear). Read ports A/B are untouched.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
ADDR_W, 4, register address width
DATA_W, 16, register data width
IDX_W (localparam), $clog2(NUM_REQ), requester index width

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant, combinational
clear_req  input  1  level request to clear the bank
clear_done  output  1  one-cycle acknowledge of a completed clear
bank_write_enable  output  1  to bank write_enable, registered
bank_address_w  output  ADDR_W  to bank address_w, registered
bank_data_in_w  output  DATA_W  to bank data_in_w, registered
bank_clear  output  1  to bank clear, registered
grant_id  output  IDX_W  index of the requester whose write is on the bank port this cycle, registered

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, rr_ptr=0.
  - All registered outputs are 0: bank_write_enable, bank_address_w, bank_data_in_w, bank_clear, clear_done, grant_id.
  - A write registered but not yet issued is dropped.
  - req_ready is 0 while reset is low.
- FSM states: IDLE, CLEAR, DONE.
- IDLE, clear_req==0:
  - Grant the first asserted req_valid, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready[g]=1 for that requester only; all other ready bits are 0.
  - Handshake completes when req_valid[g]&&req_ready[g].
- Accepted transaction:
  - Next posedge: bank_write_enable=1, bank_address_w/bank_data_in_w = requester g's addr/data, grant_id=g.
  - The bank captures it one posedge later. Acceptance-to-bank-update latency is 2 clocks.
  - Otherwise bank_write_enable=0; addr and data hold their last values.
  - rr_ptr <= (g+1) mod NUM_REQ on every accepted grant; unchanged when there is no grant.
- Back-to-back grants are allowed every cycle; throughput is 1 write per clock.
- Each requester must hold valid, addr and data stable until it sees ready.
- IDLE, clear_req==1:
  - No grants that cycle (all req_ready=0). Clear has priority over writes.
  - Next state CLEAR. The write accepted in the previous cycle still issues this cycle, so no write is lost.
- CLEAR (1 cycle):
  - bank_clear registered high for exactly this cycle; bank_write_enable=0; req_ready=0.
  - Next state DONE.
- DONE (1 cycle):
  - clear_done=1, req_ready=0, clear_req ignored.
  - Next state IDLE. The requester must drop clear_req on clear_done.
  - If clear_req is still high in IDLE, a new clear starts.
- Same-address writes from consecutive grants issue in grant order; the last one wins.
- A single valid requester is granted every cycle regardless of rr_ptr.
- Reset asserted during CLEAR or DONE: return to IDLE; bank_clear and clear_done go to 0 at that posedge.

Optional Feature:
Macro: REGBANK_ARB_STATS_EN
- Defined:
  - Adds output write_count (16 bits): total writes issued to the bank, incremented on each cycle with bank_write_enable=1, wrapping 0xFFFF->0.
  - write_count is cleared by reset and by the CLEAR state.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset low 2 cycles with req_valid=4'b1111 -> req_ready=0, all bank_* outputs 0, grant_id=0; release -> requester 0 granted first.
- req_valid=4'b1111 held 8 cycles, each requester's addr=i and data=16'hA000+i -> grant order 0,1,2,3,0,1,2,3; bank_address_w follows one cycle later; 8 consecutive cycles with bank_write_enable=1.
- Only requester 2 valid, addr=4'hF, data=16'hBEEF -> ready[2]=1 immediately; next cycle bank_write_enable=1, address 0xF, data 0xBEEF, grant_id=2.
- Accept a write from requester 1 at cycle t, raise clear_req at cycle t+1 -> write issues at t+1, bank_clear=1 only at t+2, clear_done=1 at t+3, no ready during t+1..t+3.
- clear_req held high through DONE -> second clear starts after one IDLE cycle; reset pulled low while in CLEAR -> bank_clear=0 and state IDLE at that posedge.
- REGBANK_ARB_STATS_EN: 5 writes -> write_count=5; then a clear -> write_count=0.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin arbiter for the register bank write port with clear sequencing.
// Optional write statistics counter enabled by defining REGBANK_ARB_STATS_EN.
module regbank_write_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = 4,
  parameter  int DATA_W  = 16,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_req,
  output logic                      clear_done,
  output logic                      bank_write_enable,
  output logic [ADDR_W-1:0]         bank_address_w,
  output logic [DATA_W-1:0]         bank_data_in_w,
  output logic                      bank_clear,
  output logic [IDX_W-1:0]          grant_id
`ifdef REGBANK_ARB_STATS_EN
  ,
  output logic [15:0]               write_count
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic                bank_we_q, bank_we_d;
  logic [ADDR_W-1:0]   bank_addr_q, bank_addr_d;
  logic [DATA_W-1:0]   bank_data_q, bank_data_d;
  logic                bank_clear_q, bank_clear_d;
  logic                clear_done_q, clear_done_d;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin : grant_search
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin : payload_mux
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : next_state
    int nxt;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    bank_we_d   = 1'b0;
    bank_addr_d = bank_addr_q;
    bank_data_d = bank_data_q;
    req_ready   = '0;
    nxt         = int'(grant_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          bank_we_d            = 1'b1;
          bank_addr_d          = sel_addr;
          bank_data_d          = sel_data;
          grant_id_d           = grant_idx;
          rr_ptr_d             = IDX_W'(nxt);
        end
      end
      CLEAR:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Ready must not leak out while the block is held in reset.
    if (!reset) req_ready = '0;

    bank_clear_d = (state_d == CLEAR);
    clear_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      bank_we_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_data_q  <= '0;
      bank_clear_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_data_q  <= bank_data_d;
      bank_clear_q <= bank_clear_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bank_write_enable = bank_we_q;
  assign bank_address_w    = bank_addr_q;
  assign bank_data_in_w    = bank_data_q;
  assign bank_clear        = bank_clear_q;
  assign clear_done        = clear_done_q;
  assign grant_id          = grant_id_q;

`ifdef REGBANK_ARB_STATS_EN
  logic [15:0] write_count_q, write_count_d;

  // Counts writes actually presented to the bank; a bank clear also zeroes it.
  always_comb begin
    write_count_d = write_count_q;
    if (state_q == CLEAR)  write_count_d = '0;
    else if (bank_we_q)    write_count_d = write_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) write_count_q <= '0;
    else        write_count_q <= write_count_d;
  end

  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - scoreboard bench for regbank_write_arbiter.
module tb_regbank_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid = '1;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              clear_req = 1'b0;
  logic              clear_done;
  logic              bank_write_enable;
  logic [AW-1:0]     bank_address_w;
  logic [DW-1:0]     bank_data_in_w;
  logic              bank_clear;
  logic [IW-1:0]     grant_id;
`ifdef REGBANK_ARB_STATS_EN
  logic [15:0]       write_count;
`endif

  regbank_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .clear_req(clear_req),
    .clear_done(clear_done),
    .bank_write_enable(bank_write_enable),
    .bank_address_w(bank_address_w),
    .bank_data_in_w(bank_data_in_w),
    .bank_clear(bank_clear),
    .grant_id(grant_id)
`ifdef REGBANK_ARB_STATS_EN
    ,
    .write_count(write_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] gid;
  } wr_t;

  wr_t wq[$];
  int  clr_q[$];
  int  done_q[$];

  int  nchecks = 0;
  int  nerr    = 0;

  bit            pend[N];
  logic [AW-1:0] pa[N];
  logic [DW-1:0] pd[N];
  int            rr = 0;
  int            blocked = 0;
  logic          clr_lvl = 1'b0;
  bit            mon_en = 1'b0;
  int            exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_addr[i*AW +: AW]  = pa[i];
      req_data[i*DW +: DW]  = pd[i];
    end
    clear_req = clr_lvl;
  endtask

  // Reference: clear wins in a free cycle and blocks the next two cycles;
  // otherwise the first pending requester at or after rr (mod N) is served.
  task automatic model_eval();
    logic [N-1:0] exp_ready;
    int g;
    exp_ready = '0;
    if (blocked > 0) begin
      blocked--;
    end else if (clr_lvl) begin
      clr_q.push_back(cyc + 1);
      done_q.push_back(cyc + 2);
      blocked = 2;
    end else begin
      for (int k = 0; k < N; k++) begin
        g = (rr + k) % N;
        if (pend[g]) begin
          exp_ready[g] = 1'b1;
          wq.push_back('{cyc + 1, pa[g], pd[g], IW'(g)});
          rr = (g + 1) % N;
          pend[g] = 1'b0;
          break;
        end
      end
    end
    check("req_ready", req_ready, exp_ready);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    drive(); #1;
    model_eval();
  endtask

  task automatic run(input int n, input int dens, input int clr_pct, input bit fixed);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(99) < dens) begin
          pend[i] = 1'b1;
          pa[i]   = fixed ? AW'(i) : AW'($urandom);
          pd[i]   = fixed ? DW'(16'hA000 + i) : DW'($urandom);
        end
      end
      if (!clr_lvl) clr_lvl = ($urandom_range(99) < clr_pct);
      else          clr_lvl = ($urandom_range(1) == 1);
      drive(); #1;
      model_eval();
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset     = 1'b0;
    clr_lvl   = 1'b0;
    clear_req = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    #1;
    check("ready_in_reset", req_ready, '0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      wq.delete();
      clr_q.delete();
      done_q.delete();
      rr      = 0;
      blocked = 0;
      exp_cnt = 0;
      mon_en  = 1'b1;
      if (k == 0)
        check("reset_outputs",
              {bank_write_enable, bank_address_w, bank_data_in_w, bank_clear, clear_done, grant_id}, '0);
      check("ready_in_reset", req_ready, '0);
    end
    reset = 1'b1;
    drive();
  endtask

  wr_t e;
  int  ec;

  always @(negedge clk) begin
    if (mon_en) begin
`ifdef REGBANK_ARB_STATS_EN
      check("write_count", write_count, exp_cnt);
`endif
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        check("write_missing", cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
      while (clr_q.size() > 0 && clr_q[0] < cyc) begin
        check("clear_missing", cyc, clr_q[0]);
        void'(clr_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        check("done_missing", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
      if (bank_write_enable) begin
        if (wq.size() == 0) begin
          check("unexpected_write", bank_write_enable, 1'b0);
        end else begin
          e = wq.pop_front();
          check("bank_write", {cyc, bank_address_w, bank_data_in_w, grant_id},
                {e.cyc, e.addr, e.data, e.gid});
        end
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      end
      if (bank_clear) begin
        if (clr_q.size() == 0) begin
          check("unexpected_clear", bank_clear, 1'b0);
        end else begin
          ec = clr_q.pop_front();
          check("bank_clear", cyc, ec);
        end
        exp_cnt = 0;
      end
      if (clear_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", clear_done, 1'b0);
        end else begin
          ec = done_q.pop_front();
          check("clear_done", cyc, ec);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pd[i]   = '0;
    end
    do_reset(2);

    run(8, 100, 0, 1'b1);
    run(6, 0, 0, 1'b0);

    pend[2] = 1'b1; pa[2] = 4'hF; pd[2] = 16'hBEEF;
    tick();
    tick();

    pend[1] = 1'b1; pa[1] = 4'h3; pd[1] = 16'h1234;
    tick();
    clr_lvl = 1'b1;
    tick();
    clr_lvl = 1'b0;
    repeat (3) tick();

    clr_lvl = 1'b1;
    repeat (7) tick();
    clr_lvl = 1'b0;
    repeat (2) tick();

    run(300, 30, 3, 1'b0);
    run(300, 85, 6, 1'b0);

    clr_lvl = 1'b0;
    run(8, 0, 0, 1'b0);
    clr_lvl = 1'b1;
    tick();
    do_reset(2);

    run(150, 60, 4, 1'b0);
    clr_lvl = 1'b0;
    run(10, 0, 0, 1'b0);
    @(posedge clk); #1;
    check("queues_empty", wq.size() + clr_q.size() + done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
